// File: rtl/lif_neuron_step.sv
// rtl/lif_neuron_step.sv - sequential leaky integrate-and-fire neuron core with refractory period and spike counter
// Membrane leak by 1 - 2^-shift, saturating integration, threshold fire with reset by subtraction.
module lif_neuron_step #(
    parameter  int N_STAGE = 6,
    parameter  int REF_W   = 4,
    parameter  int CNT_W   = 8,
    localparam int W       = N_STAGE + 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   ena_i,
    input  logic                   cfg_we_i,
    input  logic [2:0]             cfg_shift_i,
    input  logic [N_STAGE:0]       cfg_threshold_i,
    input  logic [REF_W-1:0]       cfg_refrac_i,
    input  logic                   step_i,
    input  logic signed [W-1:0]    in_current_i,
    output logic                   spike_o,
    output logic signed [W-1:0]    u_out_o,
    output logic                   refractory_o,
    output logic [CNT_W-1:0]       spike_count_o
);

    typedef enum logic {
        ACTIVE     = 1'b0,
        REFRACTORY = 1'b1
    } state_e;

    logic [2:0]          shift_q;
    logic [N_STAGE:0]    thr_q;
    logic [REF_W-1:0]    ref_len_q;

    logic signed [W-1:0] u_q, u_d;
    logic [REF_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                spike_q, spike_d;
    logic                refr_q, refr_d;

    state_e              state;
    logic                do_step;
    logic signed [W-1:0] leak_g;
    logic signed [W-1:0] leak_b;
    logic [W:0]          sum;
    logic signed [W-1:0] sum_sat;
    logic signed [W-1:0] s_val;
    logic signed [W-1:0] thr_s;
    logic                fire;

    assign state   = (cnt_q != '0) ? REFRACTORY : ACTIVE;
    assign do_step = ena_i & step_i;
    assign thr_s   = $signed({1'b0, thr_q});

    always_comb begin
        leak_g  = u_q >>> shift_q;
        leak_b  = (shift_q == 3'd0) ? u_q : (u_q - leak_g);

        // Sum in W+1 bits; disagreeing top two bits mean the W-bit result overflowed.
        sum     = {leak_b[W-1], leak_b} + {in_current_i[W-1], in_current_i};
        sum_sat = sum[W-1:0];
        if (!sum[W] && sum[W-1]) begin
            sum_sat = {1'b0, {(W-1){1'b1}}};
        end else if (sum[W] && !sum[W-1]) begin
            sum_sat = {1'b1, {(W-1){1'b0}}};
        end

        s_val = (state == ACTIVE) ? sum_sat : leak_b;
        fire  = (state == ACTIVE) && (thr_q != '0) && (s_val >= thr_s);
    end

    always_comb begin
        u_d     = u_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        spike_d = 1'b0;
        if (do_step) begin
            u_d     = fire ? (s_val - thr_s) : s_val;
            spike_d = fire;
            if (state == REFRACTORY) begin
                cnt_d = cnt_q - 1'b1;
            end else if (fire) begin
                cnt_d = ref_len_q;
            end
            if (fire && !(&count_q)) begin
                count_d = count_q + 1'b1;
            end
        end
        refr_d = (cnt_d != '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            u_q     <= '0;
            cnt_q   <= '0;
            count_q <= '0;
            spike_q <= 1'b0;
            refr_q  <= 1'b0;
        end else if (ena_i) begin
            u_q     <= u_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            spike_q <= spike_d;
            refr_q  <= refr_d;
        end else begin
            spike_q <= 1'b0;
        end
    end

    // A coinciding step samples the old values, so new config takes effect on the following step.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shift_q   <= '0;
            thr_q     <= '0;
            ref_len_q <= '0;
        end else if (ena_i && cfg_we_i) begin
            shift_q   <= cfg_shift_i;
            thr_q     <= cfg_threshold_i;
            ref_len_q <= cfg_refrac_i;
        end
    end

    assign spike_o       = spike_q;
    assign u_out_o       = u_q;
    assign refractory_o  = refr_q;
    assign spike_count_o = count_q;

endmodule

// File: tb/tb_lif_neuron_step.sv
// tb/tb_lif_neuron_step.sv - directed self-checking bench for lif_neuron_step
module tb_lif_neuron_step;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              ena_i;
    logic              cfg_we_i;
    logic [2:0]        cfg_shift_i;
    logic [6:0]        cfg_threshold_i;
    logic [3:0]        cfg_refrac_i;
    logic              step_i;
    logic signed [7:0] in_current_i;
    logic              spike_o;
    logic signed [7:0] u_out_o;
    logic              refractory_o;
    logic [7:0]        spike_count_o;

    int checks = 0;
    int errors = 0;

    lif_neuron_step dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .ena_i          (ena_i),
        .cfg_we_i       (cfg_we_i),
        .cfg_shift_i    (cfg_shift_i),
        .cfg_threshold_i(cfg_threshold_i),
        .cfg_refrac_i   (cfg_refrac_i),
        .step_i         (step_i),
        .in_current_i   (in_current_i),
        .spike_o        (spike_o),
        .u_out_o        (u_out_o),
        .refractory_o   (refractory_o),
        .spike_count_o  (spike_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int u, input int sp, input int rf, input int cnt);
        chk({tag, ".u"},     32'($signed(u_out_o)), u);
        chk({tag, ".spike"}, 32'(spike_o),          sp);
        chk({tag, ".refr"},  32'(refractory_o),     rf);
        chk({tag, ".count"}, 32'(spike_count_o),    cnt);
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_step(input logic signed [7:0] cur);
        step_i       = 1'b1;
        in_current_i = cur;
        tick();
        step_i       = 1'b0;
        in_current_i = '0;
    endtask

    task automatic do_cfg(input logic [2:0] sh, input logic [6:0] thr, input logic [3:0] rf);
        cfg_we_i        = 1'b1;
        cfg_shift_i     = sh;
        cfg_threshold_i = thr;
        cfg_refrac_i    = rf;
        tick();
        cfg_we_i        = 1'b0;
    endtask

    task automatic do_reset;
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        tick();
    endtask

    initial begin
        rst_n_i = 1'b0; ena_i = 1'b1; cfg_we_i = 1'b0; cfg_shift_i = '0;
        cfg_threshold_i = '0; cfg_refrac_i = '0; step_i = 1'b0; in_current_i = '0;
        tick(); tick();
        chk_state("reset", 0, 0, 0, 0);
        rst_n_i = 1'b1;
        tick();

        // T1/T2: leak by half, threshold 100, refractory 2
        do_cfg(3'd1, 7'd100, 4'd2);
        do_step(8'sd60);  chk_state("t1.s1", 60, 0, 0, 0);
        do_step(8'sd60);  chk_state("t1.s2", 90, 0, 0, 0);
        do_step(8'sd60);  chk_state("t1.s3", 5, 1, 1, 1);
        do_step(8'sd60);  chk_state("t2.s4", 3, 0, 1, 1);
        do_step(8'sd60);  chk_state("t2.s5", 2, 0, 0, 1);
        do_step(8'sd60);  chk_state("t2.s6", 61, 0, 0, 1);

        // T3: saturation both ways, spiking disabled
        do_reset();
        do_cfg(3'd0, 7'd0, 4'd0);
        do_step(8'sd100);  chk_state("t3.p1", 100, 0, 0, 0);
        do_step(8'sd100);  chk_state("t3.p2", 127, 0, 0, 0);
        do_step(-8'sd100); chk_state("t3.n1", 27, 0, 0, 0);
        do_step(-8'sd100); chk_state("t3.n2", -73, 0, 0, 0);
        do_step(-8'sd100); chk_state("t3.n3", -128, 0, 0, 0);

        // T4: arithmetic leak of a negative membrane: -100 - floor(-100/8) = -87
        do_reset();
        do_cfg(3'd3, 7'd0, 4'd0);
        do_step(-8'sd100); chk("t4.pre", 32'($signed(u_out_o)), -100);
        do_step(8'sd0);    chk("t4.leak", 32'($signed(u_out_o)), -87);

        // T5: config write coinciding with a step uses the old threshold
        do_reset();
        do_cfg(3'd0, 7'd100, 4'd0);
        cfg_we_i = 1'b1; cfg_threshold_i = 7'd50;
        step_i = 1'b1; in_current_i = 8'sd60;
        tick();
        cfg_we_i = 1'b0; step_i = 1'b0; in_current_i = '0;
        chk_state("t5.same", 60, 0, 0, 0);
        do_step(8'sd0);    chk_state("t5.fire", 10, 1, 0, 1);
        tick();            chk_state("t5.idle", 10, 0, 0, 1);

        // Spike counter saturates at 255
        do_reset();
        do_cfg(3'd0, 7'd1, 4'd0);
        do_step(8'sd127);  chk_state("sat.first", 126, 1, 0, 1);
        for (int i = 0; i < 259; i++) do_step(8'sd127);
        chk_state("sat.end", 126, 1, 0, 255);

        // T6: asynchronous reset mid-refractory
        do_reset();
        do_cfg(3'd0, 7'd50, 4'd3);
        do_step(8'sd60);   chk_state("t6.fire", 10, 1, 1, 1);
        do_step(8'sd90);   chk_state("t6.refr", 10, 0, 1, 1);
        #2 rst_n_i = 1'b0;
        #1 chk_state("t6.async", 0, 0, 0, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();

        // ena=0 freezes state and blocks config writes
        do_cfg(3'd0, 7'd0, 4'd0);
        do_step(8'sd40);   chk("ena.pre", 32'($signed(u_out_o)), 40);
        ena_i = 1'b0;
        do_step(8'sd50);   chk_state("ena.hold", 40, 0, 0, 0);
        do_cfg(3'd0, 7'd10, 4'd0);
        ena_i = 1'b1;
        do_step(8'sd0);    chk_state("ena.cfgblk", 40, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
